wb_bfm_ram_slave: RTL and testbench

//  Synthesizable Wishbone B3 slave: word-addressed RAM with byte-lane writes.
//  It is the responder end for Wishbone masters (BFM in benches, CPU/DMA in RTL).

---
 rtl/wb_bfm_ram_slave_pkg.sv | 31 +++
 rtl/wb_bfm_ram_slave_if.sv | 34 +++
 rtl/wb_bfm_ram_slave_burst_addr_next.sv | 32 +++
 rtl/wb_bfm_ram_slave.sv | 161 ++++++++++++++++
 tb/tb_wb_bfm_ram_slave.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_bfm_ram_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wb_bfm_ram_slave_pkg
// Brief   : Wishbone B3 cycle-type/burst-type codes and slave FSM state type.
// Revision: 1.0
// ============================================================================
package wb_bfm_ram_slave_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2
    } wb_state_e;

    // Only constant-address and incrementing cycles sustain a burst.
    function automatic logic cti_is_burst(input logic [2:0] cti);
        return (cti == CTI_CONST) || (cti == CTI_INCR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_bfm_ram_slave_if.sv
`default_nettype none
// ============================================================================
// Module  : wb_bfm_ram_slave_if
// Brief   : Wishbone B3 bus bundle with master and slave views.
// Revision: 1.0
// ============================================================================
interface wb_bfm_ram_slave_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0] adr;
    logic [DW-1:0] dat_w;
    logic [DW-1:0] dat_r;
    logic [3:0]    sel;
    logic          we;
    logic          cyc;
    logic          stb;
    logic [2:0]    cti;
    logic [1:0]    bte;
    logic          ack;
    logic          err;
    logic          rty;

    modport master (
        output adr, dat_w, sel, we, cyc, stb, cti, bte,
        input  dat_r, ack, err, rty
    );

    modport slave (
        input  adr, dat_w, sel, we, cyc, stb, cti, bte,
        output dat_r, ack, err, rty
    );
endinterface
`default_nettype wire

// File: rtl/wb_bfm_ram_slave_burst_addr_next.sv
`default_nettype none
// ============================================================================
// Module  : wb_bfm_ram_slave_burst_addr_next
// Brief   : Combinational next byte address of a Wishbone burst from CTI/BTE.
// Revision: 1.0
// ============================================================================
module wb_bfm_ram_slave_burst_addr_next
    import wb_bfm_ram_slave_pkg::*;
#(
    parameter int AW = 32
) (
    input  wire logic [AW-1:0] adr,
    input  wire logic [2:0]    cti,
    input  wire logic [1:0]    bte,
    output logic      [AW-1:0] adr_next
);

    // Wrapping bursts advance only the word bits inside the window.
    always_comb begin
        adr_next = adr;
        if (cti == CTI_INCR) begin
            case (bte)
                BTE_WRAP4:  adr_next = {adr[AW-1:4], adr[3:2] + 2'd1, adr[1:0]};
                BTE_WRAP8:  adr_next = {adr[AW-1:5], adr[4:2] + 3'd1, adr[1:0]};
                BTE_WRAP16: adr_next = {adr[AW-1:6], adr[5:2] + 4'd1, adr[1:0]};
                default:    adr_next = adr + AW'(4);
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_bfm_ram_slave.sv
`default_nettype none
// ============================================================================
// Module  : wb_bfm_ram_slave
// Brief   : Wishbone B3 RAM slave: byte-lane writes, CTI/BTE bursts, wait states, ERR.
// Revision: 1.0
// ============================================================================
module wb_bfm_ram_slave
    import wb_bfm_ram_slave_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  wire logic           clk_i,
    input  wire logic           rst_i,
    wb_bfm_ram_slave_if.slave   wbs
);

    localparam int            IW            = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] C_DEPTH_WORDS = AW'(DEPTH);

    wb_state_e      r_state;
    logic           r_ack;
    logic           r_err;
    logic [DW-1:0]  r_dat;
    logic [3:0]     r_cnt;
    logic [AW-1:0]  r_adr;
    logic [2:0]     r_cti;
    logic [1:0]     r_bte;

    logic [DW-1:0]  mem [DEPTH];

    logic [AW-1:0]  w_adr_next;
    logic [AW-3:0]  w_load_word;
    logic           w_load_ok;
    logic [IW-1:0]  w_load_idx;
    logic [IW-1:0]  w_wr_idx;
    logic           w_ack;
    logic           w_err;
    logic           w_beat;
    logic           w_last;
    logic           w_raise;
    logic           w_unused_bits;

    wb_bfm_ram_slave_burst_addr_next #(
        .AW       (AW)
    ) u_addr_next (
        .adr      (r_adr),
        .cti      (r_cti),
        .bte      (r_bte),
        .adr_next (w_adr_next)
    );

    assign w_ack  = r_ack & wbs.cyc & wbs.stb;
    assign w_err  = r_err & wbs.cyc & wbs.stb;
    assign w_beat = w_ack | w_err;
    assign w_last = !cti_is_burst(r_cti) || (wbs.cti == CTI_EOB);

    // Word whose response is being armed: the bus address on the first edge
    // with no wait states, the latched one after waiting, the next one mid-burst.
    always_comb begin
        case (r_state)
            IDLE:    w_load_word = wbs.adr[AW-1:2];
            WAIT:    w_load_word = r_adr[AW-1:2];
            default: w_load_word = w_adr_next[AW-1:2];
        endcase
    end

    assign w_load_ok  = ({2'b00, w_load_word} < C_DEPTH_WORDS);
    assign w_load_idx = w_load_word[IW-1:0];
    assign w_wr_idx   = r_adr[IW+1:2];

    assign w_raise = wbs.cyc & (
                        ((r_state == IDLE) && wbs.stb && (WAIT_STATES == 0)) ||
                        ((r_state == WAIT) && wbs.stb && (r_cnt == 4'd0))    ||
                        ((r_state == XFER) && w_beat && !w_last));

    assign w_unused_bits = ^w_adr_next[1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_dat   <= '0;
            r_cnt   <= '0;
            r_adr   <= '0;
            r_cti   <= CTI_CLASSIC;
            r_bte   <= BTE_LINEAR;
        end else if (!wbs.cyc) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (wbs.stb) begin
                        r_adr <= wbs.adr;
                        r_cti <= wbs.cti;
                        r_bte <= wbs.bte;
                        if (WAIT_STATES == 0) begin
                            r_state <= XFER;
                        end else begin
                            r_cnt   <= 4'(WAIT_STATES - 1);
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (wbs.stb) begin
                        if (r_cnt == 4'd0) begin
                            r_state <= XFER;
                        end else begin
                            r_cnt <= r_cnt - 4'd1;
                        end
                    end
                end
                XFER: begin
                    if (w_beat) begin
                        if (w_last) begin
                            r_ack   <= 1'b0;
                            r_err   <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_adr <= w_adr_next;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase

            // Arming a beat prefetches its read word so consecutive beats need no bubble.
            if (w_raise) begin
                r_ack <= w_load_ok;
                r_err <= !w_load_ok;
                if (w_load_ok) begin
                    r_dat <= mem[w_load_idx];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_ack && wbs.we && !rst_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wbs.sel[b]) begin
                    mem[w_wr_idx][8*b +: 8] <= wbs.dat_w[8*b +: 8];
                end
            end
        end
    end

    assign wbs.ack   = w_ack;
    assign wbs.err   = w_err;
    assign wbs.rty   = 1'b0;
    assign wbs.dat_r = r_dat;

endmodule
`default_nettype wire

// File: tb/tb_wb_bfm_ram_slave.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_bfm_ram_slave
// Brief   : Self-checking bench: directed Wishbone cases plus randomized bursts.
// Revision: 1.0
// ============================================================================
module tb_wb_bfm_ram_slave;
    import wb_bfm_ram_slave_pkg::*;

    localparam int DEPTH = 64;
    localparam int W     = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_bfm_ram_slave_if #(.AW(32), .DW(32)) bus ();

    wb_bfm_ram_slave #(
        .AW          (32),
        .DW          (32),
        .DEPTH       (DEPTH),
        .WAIT_STATES (W)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .wbs   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic        exp_on  = 1'b0;
    logic        exp_ack = 1'b0;
    logic        exp_err = 1'b0;
    logic        exp_chk = 1'b0;
    logic [31:0] exp_dat = '0;

    logic [31:0] mdl [DEPTH];
    logic [31:0] last_rd    = '0;
    logic        last_rd_ok = 1'b1;

    int          obs_acks, obs_errs, obs_first, obs_last, cyc_idx;
    logic [31:0] obs_dat [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_on) begin
            check("ack", 32'(bus.ack), 32'(exp_ack));
            check("err", 32'(bus.err), 32'(exp_err));
            check("rty", 32'(bus.rty), 32'd0);
            if (exp_chk) check("dat", bus.dat_r, exp_dat);
        end
    end

    // Address of beat k of a burst, from the Wishbone burst rules.
    function automatic logic [31:0] beat_adr(input logic [31:0] base, input logic [2:0] kind,
                                             input logic [1:0] bte, input int k);
        int unsigned span;
        if (kind != CTI_INCR) return base;
        case (bte)
            BTE_WRAP4:  span = 16;
            BTE_WRAP8:  span = 32;
            BTE_WRAP16: span = 64;
            default:    return base + 32'(4 * k);
        endcase
        return 32'((base / span) * span + ((base % span) + 4 * k) % span);
    endfunction

    task automatic mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int w;
        w = int'(a >> 2);
        for (int b = 0; b < 4; b++)
            if (s[b]) mdl[w][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic drive(input logic cyc, input logic stb, input logic [31:0] adr, input logic we,
                         input logic [3:0] sel, input logic [31:0] dat, input logic [2:0] cti,
                         input logic [1:0] bte, input logic e_ack, input logic e_err,
                         input logic e_chk, input logic [31:0] e_dat);
        bus.cyc = cyc; bus.stb = stb; bus.adr = adr; bus.we = we;
        bus.sel = sel; bus.dat_w = dat; bus.cti = cti; bus.bte = bte;
        exp_on = 1'b1; exp_ack = e_ack; exp_err = e_err; exp_chk = e_chk; exp_dat = e_dat;
        @(negedge clk);
        if (bus.ack || bus.err) begin
            if (obs_first < 0) obs_first = cyc_idx;
            obs_last = cyc_idx;
            if (bus.ack && obs_acks < 16) obs_dat[obs_acks] = bus.dat_r;
            if (bus.ack) obs_acks++;
            if (bus.err) obs_errs++;
        end
        cyc_idx++;
        @(posedge clk);
        #1;
    endtask

    task automatic obs_clear();
        obs_acks = 0; obs_errs = 0; obs_first = -1; obs_last = -1; cyc_idx = 0;
    endtask

    task automatic idle_cycle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, CTI_CLASSIC, BTE_LINEAR,
              1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    // One complete bus cycle; expected responses come from the counting rules:
    // the first termination follows W+1 strobed edges, then one beat per strobed clock.
    task automatic run_txn(input logic [31:0] base, input logic [2:0] kind, input logic [1:0] bte,
                           input logic we, input int nbeats, input logic [31:0] d0,
                           input logic [3:0] sel0, input bit rnd, input int gap_at,
                           input int gap_len);
        int          edges, done, gap_left, guard;
        logic [31:0] a, d, e_dat;
        logic [3:0]  s;
        logic [2:0]  cti;
        logic        stb, term, oor, burst, e_chk;
        edges = 0; done = 0; gap_left = gap_len; guard = 0;
        burst = (kind == CTI_CONST) || (kind == CTI_INCR);
        obs_clear();
        d = rnd ? $urandom : d0;
        s = rnd ? 4'($urandom) : sel0;
        while (done < nbeats) begin
            a   = beat_adr(base, kind, bte, done);
            stb = 1'b1;
            if (done == gap_at && gap_left > 0) begin
                stb = 1'b0;
                gap_left--;
            end else if (rnd && $urandom_range(3) == 0) begin
                stb = 1'b0;
            end
            term = stb && (edges >= W + 1);
            oor  = (a >> 2) >= DEPTH;
            if (burst) cti = (done == nbeats - 1) ? CTI_EOB : kind;
            else       cti = (rnd && $urandom_range(1) == 1) ? CTI_EOB : CTI_CLASSIC;
            e_chk = 1'b0; e_dat = '0;
            if (term && !we && !oor) begin
                e_chk = 1'b1; e_dat = mdl[int'(a >> 2)];
            end else if (term && !we && oor && last_rd_ok) begin
                e_chk = 1'b1; e_dat = last_rd;
            end
            drive(1'b1, stb, a, we, s, d, cti, bte, term && !oor, term && oor, e_chk, e_dat);
            if (stb) edges++;
            if (term) begin
                if (!oor && we)  mdl_write(a, d, s);
                if (!oor && !we) begin last_rd = mdl[int'(a >> 2)]; last_rd_ok = 1'b1; end
                done++;
                d = rnd ? $urandom : d0 + 32'(4 * done);
                s = rnd ? 4'($urandom) : sel0;
            end
            guard++;
            if (guard > 200) begin
                checks++; errors++;
                $display("FAIL txn_timeout: %0d of %0d beats, required all", done, nbeats);
                break;
            end
        end
        if (we) last_rd_ok = 1'b0;
        idle_cycle();
    endtask

    task automatic rd1(input logic [31:0] a);
        run_txn(a, CTI_CLASSIC, BTE_LINEAR, 1'b0, 1, 32'h0, 4'hF, 1'b0, -1, 0);
    endtask

    task automatic wr1(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        run_txn(a, CTI_CLASSIC, BTE_LINEAR, 1'b1, 1, d, s, 1'b0, -1, 0);
    endtask

    initial begin
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.adr = '0; bus.we = 1'b0;
        bus.sel = '0; bus.dat_w = '0; bus.cti = CTI_CLASSIC; bus.bte = BTE_LINEAR;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_ack", 32'(bus.ack), 32'd0);
        check("reset_err", 32'(bus.err), 32'd0);
        check("reset_dat", bus.dat_r, 32'd0);
        @(posedge clk);
        #1;

        // Classic write/read with the wait-state latency pinned.
        wr1(32'h10, 32'hDEADBEEF, 4'hF);
        check("t1_wr_latency", 32'(obs_first), 32'd3);
        check("t1_wr_acks", 32'(obs_acks), 32'd1);
        rd1(32'h10);
        check("t1_rd_latency", 32'(obs_first), 32'd3);
        check("t1_rd_data", obs_dat[0], 32'hDEADBEEF);

        // Single byte lane.
        wr1(32'h10, 32'h0000AB00, 4'b0010);
        rd1(32'h10);
        check("t2_rd_data", obs_dat[0], 32'hDEADABEF);

        // Fill memory with address-tagged words using linear bursts.
        for (int i = 0; i < DEPTH / 16; i++)
            run_txn(32'(i * 64), CTI_INCR, BTE_LINEAR, 1'b1, 16, 32'hC0DE0000 + 32'(i * 64),
                    4'hF, 1'b0, -1, 0);

        // Wrap4 read burst.
        run_txn(32'h08, CTI_INCR, BTE_WRAP4, 1'b0, 4, 32'h0, 4'hF, 1'b0, -1, 0);
        check("t3_acks", 32'(obs_acks), 32'd4);
        check("t3_back_to_back", 32'(obs_last - obs_first), 32'd3);
        check("t3_beat0", obs_dat[0], 32'hC0DE0008);
        check("t3_beat1", obs_dat[1], 32'hC0DE000C);
        check("t3_beat2", obs_dat[2], 32'hC0DE0000);
        check("t3_beat3", obs_dat[3], 32'hC0DE0004);

        // Linear write burst with a two-clock master wait after the first beat.
        run_txn(32'h20, CTI_INCR, BTE_LINEAR, 1'b1, 3, 32'h44440000, 4'hF, 1'b0, 1, 2);
        check("t4_acks", 32'(obs_acks), 32'd3);
        rd1(32'h20); check("t4_word0", obs_dat[0], 32'h44440000);
        rd1(32'h24); check("t4_word1", obs_dat[0], 32'h44440004);
        rd1(32'h28); check("t4_word2", obs_dat[0], 32'h44440008);

        // Out of range: ERR, data held, no aliased write.
        rd1(32'h14);
        rd1(32'(DEPTH * 4));
        check("t5_rd_errs", 32'(obs_errs), 32'd1);
        check("t5_rd_acks", 32'(obs_acks), 32'd0);
        wr1(32'(DEPTH * 4), 32'h5A5A5A5A, 4'hF);
        check("t5_wr_errs", 32'(obs_errs), 32'd1);
        rd1(32'h00);
        check("t5_word0_intact", obs_dat[0], 32'hC0DE0000);

        // cyc dropped while waiting: no response, no write.
        obs_clear();
        for (int c = 0; c < W; c++)
            drive(1'b1, 1'b1, 32'h30, 1'b1, 4'hF, 32'h66666666, CTI_CLASSIC, BTE_LINEAR,
                  1'b0, 1'b0, 1'b0, 32'h0);
        idle_cycle();
        idle_cycle();
        check("t6_abort_resp", 32'(obs_acks + obs_errs), 32'd0);
        rd1(32'h30);
        check("t6_abort_word", obs_dat[0], 32'hC0DE0030);

        // Reset during a write burst while the master is waiting.
        obs_clear();
        for (int c = 0; c < W + 1; c++)
            drive(1'b1, 1'b1, 32'h40, 1'b1, 4'hF, 32'h11111111, CTI_INCR, BTE_LINEAR,
                  1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 32'h40, 1'b1, 4'hF, 32'h11111111, CTI_INCR, BTE_LINEAR,
              1'b1, 1'b0, 1'b0, 32'h0);
        mdl_write(32'h40, 32'h11111111, 4'hF);
        drive(1'b1, 1'b1, 32'h44, 1'b1, 4'hF, 32'h22222222, CTI_INCR, BTE_LINEAR,
              1'b1, 1'b0, 1'b0, 32'h0);
        mdl_write(32'h44, 32'h22222222, 4'hF);
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'h48, 1'b1, 4'hF, 32'h33333333, CTI_INCR, BTE_LINEAR,
              1'b0, 1'b0, 1'b0, 32'h0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, CTI_CLASSIC, BTE_LINEAR,
              1'b0, 1'b0, 1'b1, 32'h0);
        last_rd = '0; last_rd_ok = 1'b1;
        check("t6_rst_acks", 32'(obs_acks), 32'd2);
        rd1(32'h48); check("t6_rst_no_write", obs_dat[0], 32'hC0DE0048);
        rd1(32'h40); check("t6_rst_beat0", obs_dat[0], 32'h11111111);

        // Randomized traffic across all cycle and burst types, including the upper edge.
        for (int n = 0; n < 150; n++) begin
            logic [2:0] kind;
            int         nb;
            case ($urandom_range(2))
                0:       kind = CTI_CLASSIC;
                1:       kind = CTI_CONST;
                default: kind = CTI_INCR;
            endcase
            nb = (kind == CTI_CLASSIC) ? 1 : int'($urandom_range(6, 1));
            run_txn(32'($urandom_range(DEPTH + 3) * 4), kind, 2'($urandom), 1'($urandom),
                    nb, 32'h0, 4'hF, 1'b1, -1, 0);
        end

        exp_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
